// File: rtl/salamander_pkg.sv
// Shared types for the Salamander-4 core.
// Opcode encodings and sequencer state enumeration.
package salamander_pkg;

   localparam int INSTR_W_DFLT = 8;
   localparam int ADDR_W_DFLT  = 5;

   typedef logic [3:0] opc_t;

   localparam opc_t OPC_NOP  = 4'h0;
   localparam opc_t OPC_JMPR = 4'h1;
   localparam opc_t OPC_HLT  = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      ADVANCE,
      HALT
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM for the Salamander-4 core.
// Optional fetch watchdog: define SEQ_WATCHDOG_EN.
module pc_sequencer
   import salamander_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DFLT,
   parameter int INSTR_W = INSTR_W_DFLT,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   output logic               imem_req,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               pc_max,
   output logic               pc_inc,
   output logic [ADDR_W-1:0]  pc_inc_val,
   output logic [INSTR_W-1:0] ir,
   output logic               exec_valid,
   input  logic               exec_done,
   output logic               busy,
`ifdef SEQ_WATCHDOG_EN
   output logic               fetch_err,
`endif
   output logic               halted
);

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] step_q, step_nxt;
   logic              ir_ld;
   logic              wd_trip;
   opc_t              opc;
   logic [3:0]        opnd;

   assign opc  = ir[INSTR_W-1 -: 4];
   assign opnd = ir[3:0];
   assign busy = (state != IDLE) && (state != HALT);

`ifdef SEQ_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wd_cnt;

   // Trip on the request cycle that would bring the count to TIMEOUT.
   assign wd_trip = (state == FETCH) && !pc_max && !imem_ack &&
                    (wd_cnt == CNT_W'(TIMEOUT - 1));

   // Count unanswered request cycles; cleared outside FETCH.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_cnt    <= '0;
         fetch_err <= 1'b0;
      end else begin
         if (state != FETCH)
            wd_cnt <= '0;
         else if (imem_req && !imem_ack)
            wd_cnt <= wd_cnt + CNT_W'(1);
         if (wd_trip)
            fetch_err <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT != 0);
   assign wd_trip        = 1'b0;
`endif

   // State, step amount and instruction register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         step_q <= '0;
         ir     <= '0;
      end else begin
         state  <= state_nxt;
         step_q <= step_nxt;
         if (ir_ld)
            ir <= imem_data;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt  = state;
      step_nxt   = step_q;
      ir_ld      = 1'b0;
      imem_req   = 1'b0;
      exec_valid = 1'b0;
      pc_inc     = 1'b0;
      pc_inc_val = '0;
      halted     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = FETCH;
         end
         FETCH: begin
            if (pc_max) begin
               state_nxt = HALT;
            end else begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_ld     = 1'b1;
                  state_nxt = DECODE;
               end else if (wd_trip) begin
                  state_nxt = HALT;
               end
            end
         end
         DECODE: begin
            unique case (1'b1)
               opc == OPC_HLT: begin
                  state_nxt = HALT;
               end
               opc == OPC_NOP: begin
                  step_nxt  = ADDR_W'(1);
                  state_nxt = ADVANCE;
               end
               (opc == OPC_JMPR) && (opnd != '0): begin
                  step_nxt  = ADDR_W'(opnd);
                  state_nxt = ADVANCE;
               end
               (opc == OPC_JMPR) && (opnd == '0): begin
                  state_nxt = FETCH;
               end
               default: begin
                  state_nxt = EXEC;
               end
            endcase
         end
         EXEC: begin
            exec_valid = 1'b1;
            if (exec_done) begin
               step_nxt  = ADDR_W'(1);
               state_nxt = ADVANCE;
            end
         end
         ADVANCE: begin
            pc_inc     = 1'b1;
            pc_inc_val = step_q;
            state_nxt  = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer.
// Watchdog checks follow SEQ_WATCHDOG_EN.
module tb_pc_sequencer;

   logic       clk;
   logic       rstn;
   logic       start;
   logic       imem_req;
   logic       imem_ack;
   logic [7:0] imem_data;
   logic       pc_max;
   logic       pc_inc;
   logic [4:0] pc_inc_val;
   logic [7:0] ir;
   logic       exec_valid;
   logic       exec_done;
   logic       busy;
   logic       halted;
`ifdef SEQ_WATCHDOG_EN
   logic       fetch_err;
`endif

   logic [7:0] prog [0:31];
   logic [4:0] pc_m;
   logic [4:0] pc_init;
   logic       pc_max_r;
   logic       auto_ack;
   logic [5:0] pc_sum;

   int errors = 0;
   int checks = 0;

   pc_sequencer dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .imem_req   (imem_req),
      .imem_ack   (imem_ack),
      .imem_data  (imem_data),
      .pc_max     (pc_max),
      .pc_inc     (pc_inc),
      .pc_inc_val (pc_inc_val),
      .ir         (ir),
      .exec_valid (exec_valid),
      .exec_done  (exec_done),
      .busy       (busy),
`ifdef SEQ_WATCHDOG_EN
      .fetch_err  (fetch_err),
`endif
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait memory and a 5-bit PC with sticky wrap flag.
   assign imem_ack  = auto_ack & imem_req;
   assign imem_data = prog[pc_m];
   assign pc_max    = pc_max_r;
   assign pc_sum    = {1'b0, pc_m} + {1'b0, pc_inc_val};

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_m     <= pc_init;
         pc_max_r <= 1'b0;
      end else if (pc_inc) begin
         pc_m <= pc_sum[4:0];
         if (pc_sum[5])
            pc_max_r <= 1'b1;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_prog();
      for (int i = 0; i < 32; i++)
         prog[i] = 8'hF0;
   endtask

   task automatic do_reset(input logic [4:0] pi);
      pc_init   = pi;
      start     = 1'b0;
      exec_done = 1'b0;
      auto_ack  = 1'b1;
      rstn      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      start = 1'b1;
   endtask

   task automatic test_reset();
      fill_prog();
      pc_init   = 5'd0;
      start     = 1'b0;
      exec_done = 1'b0;
      auto_ack  = 1'b1;
      rstn      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({imem_req, exec_valid, pc_inc, busy, halted} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 00000",
                  {imem_req, exec_valid, pc_inc, busy, halted});
      end
      checks++;
      if ({pc_inc_val, ir} !== 13'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", {pc_inc_val, ir});
      end
      // Abort a stalled execute with an asynchronous reset.
      prog[0] = 8'h3A;
      do_reset(5'd0);
      for (int c = 1; c <= 3; c++) begin
         nxt();
         if (c == 1) start = 1'b0;
      end
      checks++;
      if (exec_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_exec: got ev=%b busy=%b want 1 1",
                  exec_valid, busy);
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({imem_req, exec_valid, pc_inc, busy, halted} !== 5'b0) begin
         errors++;
         $display("FAIL reset_async_ctl: got %b want 00000",
                  {imem_req, exec_valid, pc_inc, busy, halted});
      end
      checks++;
      if ({pc_inc_val, ir} !== 13'h0) begin
         errors++;
         $display("FAIL reset_async_data: got %h want 0", {pc_inc_val, ir});
      end
`ifdef SEQ_WATCHDOG_EN
      checks++;
      if (fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_fetch_err: got %b want 0", fetch_err);
      end
`endif
   endtask

   task automatic test_linear();
      logic       e_inc, e_req, e_halt;
      logic [4:0] e_val;
      fill_prog();
      prog[0] = 8'h00;
      prog[1] = 8'h00;
      prog[2] = 8'hF0;
      do_reset(5'd0);
      for (int c = 1; c <= 12; c++) begin
         nxt();
         if (c == 1) start = 1'b0;
         e_inc  = (c == 3) || (c == 6);
         e_val  = e_inc ? 5'd1 : 5'd0;
         e_req  = (c == 1) || (c == 4) || (c == 7);
         e_halt = (c >= 9);
         checks++;
         if (pc_inc !== e_inc || pc_inc_val !== e_val) begin
            errors++;
            $display("FAIL linear_inc c%0d: got %b/%0d want %b/%0d",
                     c, pc_inc, pc_inc_val, e_inc, e_val);
         end
         checks++;
         if (imem_req !== e_req) begin
            errors++;
            $display("FAIL linear_req c%0d: got %b want %b",
                     c, imem_req, e_req);
         end
         checks++;
         if (halted !== e_halt || busy !== !e_halt) begin
            errors++;
            $display("FAIL linear_halt c%0d: got h=%b b=%b want h=%b",
                     c, halted, busy, e_halt);
         end
      end
      checks++;
      if (ir !== 8'hF0) begin
         errors++;
         $display("FAIL linear_ir: got %h want f0", ir);
      end
   endtask

   task automatic test_jump();
      logic       e_inc;
      logic [4:0] e_val;
      fill_prog();
      prog[2] = 8'h15;
      prog[7] = 8'hF0;
      prog[3] = 8'h00;
      do_reset(5'd2);
      for (int c = 1; c <= 6; c++) begin
         nxt();
         if (c == 1) start = 1'b0;
         e_inc = (c == 3);
         e_val = e_inc ? 5'd5 : 5'd0;
         checks++;
         if (pc_inc !== e_inc || pc_inc_val !== e_val) begin
            errors++;
            $display("FAIL jump_inc c%0d: got %b/%0d want %b/%0d",
                     c, pc_inc, pc_inc_val, e_inc, e_val);
         end
         if (c == 5) begin
            checks++;
            if (ir !== 8'hF0) begin
               errors++;
               $display("FAIL jump_target_ir: got %h want f0", ir);
            end
         end
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL jump_halt: got %b want 1", halted);
      end
      // Zero-operand jump refetches the same address.
      fill_prog();
      prog[0] = 8'h10;
      prog[1] = 8'h00;
      do_reset(5'd0);
      for (int c = 1; c <= 5; c++) begin
         nxt();
         if (c == 1) start = 1'b0;
         checks++;
         if (pc_inc !== 1'b0) begin
            errors++;
            $display("FAIL jmp0_inc c%0d: got %b want 0", c, pc_inc);
         end
         checks++;
         if (imem_req !== ((c == 1) || (c == 3))) begin
            errors++;
            $display("FAIL jmp0_req c%0d: got %b want %b",
                     c, imem_req, (c == 1) || (c == 3));
         end
         if (c == 3) prog[0] = 8'hF0;
      end
      checks++;
      if (halted !== 1'b1 || ir !== 8'hF0) begin
         errors++;
         $display("FAIL jmp0_halt: got h=%b ir=%h want h=1 ir=f0",
                  halted, ir);
      end
   endtask

   task automatic test_exec_stall();
      logic       e_ev, e_inc;
      logic [4:0] e_val;
      fill_prog();
      prog[0] = 8'h3A;
      prog[1] = 8'hF0;
      do_reset(5'd0);
      for (int c = 1; c <= 10; c++) begin
         nxt();
         if (c == 1) start = 1'b0;
         exec_done = (c == 2) || (c == 6) || (c == 7);
         e_ev  = (c >= 3) && (c <= 6);
         e_inc = (c == 7);
         e_val = e_inc ? 5'd1 : 5'd0;
         checks++;
         if (exec_valid !== e_ev) begin
            errors++;
            $display("FAIL exec_valid c%0d: got %b want %b",
                     c, exec_valid, e_ev);
         end
         checks++;
         if (pc_inc !== e_inc || pc_inc_val !== e_val) begin
            errors++;
            $display("FAIL exec_inc c%0d: got %b/%0d want %b/%0d",
                     c, pc_inc, pc_inc_val, e_inc, e_val);
         end
         checks++;
         if ($countones({imem_req, exec_valid, pc_inc}) > 1) begin
            errors++;
            $display("FAIL exec_onehot c%0d: got %b want at most one",
                     c, {imem_req, exec_valid, pc_inc});
         end
      end
      exec_done = 1'b0;
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL exec_halt: got %b want 1", halted);
      end
   endtask

   task automatic test_wrap();
      logic e_inc;
      fill_prog();
      prog[31] = 8'h00;
      prog[0]  = 8'h00;
      do_reset(5'd31);
      for (int c = 1; c <= 8; c++) begin
         nxt();
         if (c == 1) start = 1'b0;
         e_inc = (c == 3);
         checks++;
         if (pc_inc !== e_inc) begin
            errors++;
            $display("FAIL wrap_inc c%0d: got %b want %b", c, pc_inc, e_inc);
         end
         checks++;
         if (imem_req !== (c == 1)) begin
            errors++;
            $display("FAIL wrap_req c%0d: got %b want %b",
                     c, imem_req, c == 1);
         end
         checks++;
         if (halted !== (c >= 5)) begin
            errors++;
            $display("FAIL wrap_halt c%0d: got %b want %b",
                     c, halted, c >= 5);
         end
      end
      prog[0] = 8'h3A;
      checks++;
      if (ir !== 8'h00) begin
         errors++;
         $display("FAIL wrap_ir: got %h want 00", ir);
      end
   endtask

   task automatic test_watchdog();
      fill_prog();
      do_reset(5'd0);
      auto_ack = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         nxt();
         if (c == 1) start = 1'b0;
`ifdef SEQ_WATCHDOG_EN
         checks++;
         if (imem_req !== (c <= 15)) begin
            errors++;
            $display("FAIL wd_req c%0d: got %b want %b",
                     c, imem_req, c <= 15);
         end
         checks++;
         if (fetch_err !== (c >= 16) || halted !== (c >= 16)) begin
            errors++;
            $display("FAIL wd_err c%0d: got e=%b h=%b want %b",
                     c, fetch_err, halted, c >= 16);
         end
`else
         checks++;
         if (imem_req !== 1'b1 || halted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_wait c%0d: got r=%b h=%b b=%b want 1 0 1",
                     c, imem_req, halted, busy);
         end
`endif
      end
      auto_ack = 1'b1;
   endtask

   initial begin
      test_reset();
      test_linear();
      test_jump();
      test_exec_stall();
      test_wrap();
      test_watchdog();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
